// File: rtl/serial_cmp_pkg.sv
// Shared types and defaults for the serial word comparator.
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN (stop comparing at the first mismatch).
package serial_cmp_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/xnor_gate.sv
// Two-input XNOR cell built purely from NAND gates; the per-bit compare element.
module xnor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  logic n_ab;
  logic n_a;
  logic n_b;
  logic x_or;

  // Classic four-NAND XOR followed by a NAND used as an inverter.
  assign n_ab = ~(a & b);
  assign n_a  = ~(a & n_ab);
  assign n_b  = ~(b & n_ab);
  assign x_or = ~(n_a & n_b);
  assign y    = ~(x_or & x_or);

endmodule

// File: rtl/serial_word_comparator.sv
// Bit-serial equality comparator: one shared XNOR cell walks both words LSB first.
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN -- finish on the first mismatch
// instead of always spending WIDTH compare cycles.
module serial_word_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned IDX_W = $clog2(WIDTH),
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [IDX_W-1:0] mismatch_idx,
  output logic [CNT_W-1:0] match_count
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [IDX_W-1:0] bit_cnt;
  logic             mm_seen;
  logic             bit_eq_c;
  logic             accept_c;
  logic             last_bit_c;
  logic             mm_first_c;
  logic             busy_d;
  logic             done_d;

  // The single compare element sees the current LSB of each shift register.
  xnor_gate u_xnor (
    .a (sh_a[0]),
    .b (sh_b[0]),
    .y (bit_eq_c)
  );

  // Decode of the per-cycle events the FSM and datapath act on.
  always_comb begin
    accept_c   = (state == IDLE) && start;
    last_bit_c = (bit_cnt == IDX_W'(WIDTH - 1));
    mm_first_c = (state == COMPARE) && !bit_eq_c && !mm_seen;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = COMPARE;
      end
      COMPARE: begin
        if (last_bit_c) next_state = DONE;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (mm_first_c) next_state = DONE;
`endif
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs derived from the upcoming state so they register cleanly.
  always_comb begin
    busy_d = (next_state != IDLE);
    done_d = (next_state == DONE);
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Operand capture, shifting and result accumulation; results hold outside COMPARE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a         <= '0;
      sh_b         <= '0;
      bit_cnt      <= '0;
      mm_seen      <= 1'b0;
      equal        <= 1'b0;
      mismatch_idx <= '0;
      match_count  <= '0;
    end else if (accept_c) begin
      sh_a         <= a;
      sh_b         <= b;
      bit_cnt      <= '0;
      mm_seen      <= 1'b0;
      equal        <= 1'b1;
      mismatch_idx <= '0;
      match_count  <= '0;
    end else if (state == COMPARE) begin
      if (bit_eq_c) begin
        match_count <= match_count + CNT_W'(1);
      end else if (mm_first_c) begin
        mismatch_idx <= bit_cnt;
        equal        <= 1'b0;
        mm_seen      <= 1'b1;
      end
      sh_a    <= sh_a >> 1;
      sh_b    <= sh_b >> 1;
      bit_cnt <= bit_cnt + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_serial_word_comparator.sv
// Self-checking bench for serial_word_comparator (WIDTH = 8).
// Expected results come from a word-level model: XOR of the operands, popcount
// and lowest set bit, honouring SERIAL_CMP_EARLY_EXIT_EN when defined.
module tb_serial_word_comparator;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic             equal;
  logic [IDX_W-1:0] mismatch_idx;
  logic [CNT_W-1:0] match_count;

  int checks = 0;
  int errors = 0;

  serial_word_comparator #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .equal        (equal),
    .mismatch_idx (mismatch_idx),
    .match_count  (match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: latency counted in edges after the accepting edge.
  function automatic void ref_model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                    output logic eq, output logic [31:0] idx,
                                    output logic [31:0] cnt, output int lat);
    logic [WIDTH-1:0] diff;
    diff = av ^ bv;
    eq   = (diff == '0);
    idx  = 32'd0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (diff[i]) idx = 32'(i);
    end
    cnt = 32'(WIDTH) - 32'($countones(diff));
    lat = int'(WIDTH);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    if (!eq) begin
      cnt = idx;
      lat = int'(idx) + 1;
    end
`endif
  endfunction

  // Present operands with start for one edge, then scramble the operand inputs.
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
  endtask

  // Count edges until done is seen (bounded); busy must stay high meanwhile.
  task automatic wait_done(input string tag, input int n0, output int n);
    logic busy_bad;
    busy_bad = 1'b0;
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] av,
                              input logic [WIDTH-1:0] bv, input int n);
    logic        eq;
    logic [31:0] idx;
    logic [31:0] cnt;
    int          lat;
    ref_model(av, bv, eq, idx, cnt, lat);
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_equal"}, 32'(equal), 32'(eq));
    chk({tag, "_idx"}, 32'(mismatch_idx), idx);
    chk({tag, "_count"}, 32'(match_count), cnt);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, {15'd0, equal, 8'(mismatch_idx), 8'(match_count)},
        {15'd0, eq, 8'(idx), 8'(cnt)});
  endtask

  task automatic run(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int n;
    launch(av, bv);
    wait_done(tag, 0, n);
    check_result(tag, av, bv, n);
  endtask

  initial begin
    int          n;
    logic        saw_done;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    // Reset and idle.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", {23'd0, busy, done, equal, 3'(mismatch_idx), 4'(match_count)}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'({busy, done}), 32'd0);
    end

    // Directed comparisons.
    run("equal_a5", 8'hA5, 8'hA5);
    run("mismatch_f0_f4", 8'hF0, 8'hF4);
    run("multi_00_81", 8'h00, 8'h81);
    run("msb_only", 8'h80, 8'h00);

    // start while busy with other operands is ignored.
    launch(8'h12, 8'h32);
    n = 0;
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    wait_done("ignore", n, n);
    check_result("ignore", 8'h12, 8'h32, n);

    // start held high: second run begins after exactly one idle cycle.
    @(negedge clk);
    a = 8'h5A;
    b = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    a = 8'hC3;
    b = 8'hC1;
    wait_done("held1", 0, n);
    check_result("held1", 8'h5A, 8'h5A, n);
    @(negedge clk);
    chk("held_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    wait_done("held2", 0, n);
    check_result("held2", 8'hC3, 8'hC1, n);

    // Asynchronous reset in the middle of a comparison.
    launch(8'h0F, 8'hF0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {23'd0, busy, done, equal, 3'(mismatch_idx), 4'(match_count)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("midreset_no_done", 32'(saw_done), 32'd0);
    run("after_reset_3c", 8'h3C, 8'h3C);

    // Randomized comparisons, biased toward equal and single-bit differences.
    for (int i = 0; i < 16; i++) begin
      ra = WIDTH'($urandom);
      case (i % 4)
        0:       rb = ra;
        1:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      run("random", ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_comparator.md
Name: serial_word_comparator

Overview:
- Compares two WIDTH-bit words one bit per clock through a single shared two-input XNOR cell.
- Sequences the cell with a start/busy/done handshake; reports word equality, index of the first mismatch and count of matching bits.
- Sits between the lab's register/operand logic and the gate-level XNOR datapath.
- Trades WIDTH cycles of latency for one XNOR instance instead of WIDTH.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- IDX_W, $clog2(WIDTH), width of mismatch_idx.
- CNT_W, $clog2(WIDTH+1), width of match_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a comparison; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high in COMPARE and DONE states.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- equal  output  1  1 when all compared bits matched.
- mismatch_idx  output  IDX_W  bit index of the first mismatch, LSB = 0; 0 when equal.
- match_count  output  CNT_W  number of matching bit positions compared.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, shift registers=0, bit counter=0; busy=0, done=0, equal=0, mismatch_idx=0, match_count=0. Applies immediately, including mid-comparison. In-flight results are discarded and no done pulse is produced.
- FSM states:
  - IDLE -> COMPARE on a clk edge with start=1. At that edge: load a, b into shift regs; clear counter, match_count and the first-mismatch flag; set equal=1 provisionally.
  - COMPARE: XNOR cell inputs are the shift-reg LSBs; each edge:
    - if the XNOR output is 1, match_count += 1;
    - else if no mismatch has been recorded yet, mismatch_idx = counter, equal = 0, set the first-mismatch flag.
    - Then shift both regs right by 1 and counter += 1.
    - After the edge processing bit WIDTH-1, go to DONE.
  - DONE: done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
- Latency: start accepted at edge E0; bits processed at edges E1..E_WIDTH; done high during the cycle following E_WIDTH; busy falls at edge E_WIDTH+1.
- start while busy=1 is ignored; no queuing. Operands a/b may change freely after the accepting edge.
- start held high continuously: a new comparison is accepted on the first edge back in IDLE, i.e. one idle cycle between runs.
- equal, mismatch_idx and match_count hold their values from done until the next accepted start.
- match_count never exceeds WIDTH. Counter saturation is not needed: it stops at WIDTH-1 by construction.
- The comparison is purely positional; no signed or arithmetic interpretation of the operands.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN
- Defined: COMPARE -> DONE on the edge that records the first mismatch.
  - Latency = k+2 edges from start for a mismatch at index k.
  - match_count = k, the matches before the mismatch.
  - Equal words still take the full WIDTH cycles.
- Undefined: always WIDTH compare cycles; match_count counts all matching positions.

Decomposition:
- Shared package serial_cmp_pkg:
  - state enum: IDLE=2'd0, COMPARE=2'd1, DONE=2'd2;
  - default WIDTH constant.
- One sub-module instance: the existing NAND-built xnor_gate cell, used as the per-bit compare element. All sequencing, shifting and counting live in serial_word_comparator.

Test Plan:
- Reset then idle: rst_n low 3 cycles, start=0 -> all outputs 0, busy=0 throughout.
- Equal words, WIDTH=8: a=b=8'hA5, start one cycle -> busy for 9 cycles, done pulse 9 edges after start; equal=1, mismatch_idx=0, match_count=8.
- Mismatch: a=8'hF0, b=8'hF4, full mode -> equal=0, mismatch_idx=2, match_count=7, done at edge 9. With SERIAL_CMP_EARLY_EXIT_EN: done at edge 4, match_count=2.
- Multiple mismatches: a=8'h00, b=8'h81 -> mismatch_idx=0, match_count=6 (full mode).
- start asserted while busy with different operands -> ignored; the first result is unchanged. start held high -> second run begins one cycle after done.
- rst_n pulsed low at compare cycle 4 -> busy=0 immediately, no done pulse; a subsequent start with a=b=8'h3C gives equal=1, match_count=8.
